// File: rtl/drac_pkg.sv
// drac_pkg: shared dcache request type, arbiter state encoding and defaults
package drac_pkg;
  localparam int STARVE_LIMIT_DEF = 4;
  typedef struct packed {
    logic [39:0] addr;
    logic [63:0] data;
    logic [3:0]  instr_type;
    logic [3:0]  mem_op;
    logic [2:0]  funct3;
    logic [4:0]  rd;
  } dcache_req_t;
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t IDLE  = 2'd0;
  localparam arb_state_t ISSUE = 2'd1;
  localparam arb_state_t WAIT  = 2'd2;
  localparam arb_state_t DRAIN = 2'd3;
endpackage

// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter: shares one dcache port between the LSU and the page-table walker
module dcache_port_arbiter
  import drac_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        kill_i,
  input  logic        lsu_valid_i,
  input  dcache_req_t lsu_req_i,
  output logic        lsu_lock_o,
  output logic        lsu_ready_o,
  output logic [63:0] lsu_data_o,
  input  logic        ptw_valid_i,
  input  dcache_req_t ptw_req_i,
  output logic        ptw_lock_o,
  output logic        ptw_ready_o,
  output logic [63:0] ptw_data_o,
  output logic        dc_valid_o,
  output dcache_req_t dc_req_o,
  input  logic        dc_lock_i,
  input  logic        dc_ready_i,
  input  logic [63:0] dc_data_i,
  output logic        owner_o
);
  arb_state_t  state_q, state_d;
  logic [2:0]  starve_q;
  dcache_req_t req_q;
  logic        owner_q;
  logic        idle, lsu_kill, lsu_win, ptw_win, rsp;
  // grants are only possible in IDLE and never while reset is held, so locks read 1 in reset
  assign idle     = state_q == IDLE && !rst_i;
  assign lsu_kill = !owner_q && kill_i;
  assign lsu_win  = idle && lsu_valid_i && !kill_i && (starve_q >= 3'(STARVE_LIMIT) || !ptw_valid_i);
  assign ptw_win  = idle && ptw_valid_i && !lsu_win;
  assign rsp      = state_q == WAIT && dc_ready_i;
  assign lsu_lock_o  = !lsu_win;
  assign ptw_lock_o  = !ptw_win;
  assign lsu_ready_o = rsp && !owner_q && !kill_i;
  assign ptw_ready_o = rsp && owner_q;
  assign lsu_data_o  = lsu_ready_o ? dc_data_i : '0;
  assign ptw_data_o  = ptw_ready_o ? dc_data_i : '0;
  assign dc_valid_o  = state_q == ISSUE && !lsu_kill;
  assign dc_req_o    = req_q;
  assign owner_o     = owner_q;
  // next-state: a killed LSU request is dropped in ISSUE and drained in WAIT
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (lsu_win || ptw_win) ? ISSUE : IDLE;
      ISSUE:   state_d = lsu_kill ? IDLE : dc_lock_i ? ISSUE : WAIT;
      WAIT:    state_d = dc_ready_i ? IDLE : lsu_kill ? DRAIN : WAIT;
      DRAIN:   state_d = dc_ready_i ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  // state, latched request/owner and the LSU starvation counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      starve_q <= '0;
      req_q    <= '0;
      owner_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (lsu_win || ptw_win) begin
        req_q   <= ptw_win ? ptw_req_i : lsu_req_i;
        owner_q <= ptw_win;
      end
      starve_q <= (!lsu_valid_i || lsu_win) ? 3'd0 :
                  (ptw_win && starve_q != 3'd7) ? starve_q + 3'd1 : starve_q;
    end
  end
endmodule

// File: tb/tb_dcache_port_arbiter.sv
// tb_dcache_port_arbiter: directed stimulus with scoreboarded issue and response checks
module tb_dcache_port_arbiter;
  import drac_pkg::*;
  logic        clk_i = 1'b0;
  logic        rst_i, kill_i, lsu_valid_i, ptw_valid_i, dc_lock_i, dc_ready_i;
  dcache_req_t lsu_req_i, ptw_req_i, dc_req_o;
  logic [63:0] dc_data_i, lsu_data_o, ptw_data_o;
  logic        lsu_lock_o, lsu_ready_o, ptw_lock_o, ptw_ready_o, dc_valid_o, owner_o;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [40:0]  iss_q[$];
  logic [129:0] rsp_q[$];

  dcache_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .kill_i(kill_i),
    .lsu_valid_i(lsu_valid_i), .lsu_req_i(lsu_req_i), .lsu_lock_o(lsu_lock_o),
    .lsu_ready_o(lsu_ready_o), .lsu_data_o(lsu_data_o),
    .ptw_valid_i(ptw_valid_i), .ptw_req_i(ptw_req_i), .ptw_lock_o(ptw_lock_o),
    .ptw_ready_o(ptw_ready_o), .ptw_data_o(ptw_data_o),
    .dc_valid_o(dc_valid_o), .dc_req_o(dc_req_o), .dc_lock_i(dc_lock_i),
    .dc_ready_i(dc_ready_i), .dc_data_i(dc_data_i), .owner_o(owner_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic dcache_req_t mk(input logic [39:0] a);
    dcache_req_t r;
    r.addr       = a;
    r.data       = {24'h0, a} ^ 64'h5555;
    r.instr_type = 4'h1;
    r.mem_op     = a[11:8];
    r.funct3     = 3'd3;
    r.rd         = a[4:0];
    return r;
  endfunction

  function automatic logic [129:0] er(input logic p, input logic [63:0] d);
    return p ? {1'b0, 1'b1, 64'h0, d} : {1'b1, 1'b0, d, 64'h0};
  endfunction

  task automatic chk(input string nm, input logic [159:0] got, input logic [159:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // monitor: every accepted dcache issue and every requester response is scoreboarded
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (dc_valid_o && !dc_lock_i) begin
        if (iss_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_issue: got owner %0b addr %0h want none", owner_o, dc_req_o.addr);
        end else chk("issue", {owner_o, dc_req_o.addr}, iss_q.pop_front());
      end
      if (lsu_ready_o || ptw_ready_o) begin
        if (rsp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_ready: got lsu %0b ptw %0b want none", lsu_ready_o, ptw_ready_o);
        end else chk("response", {lsu_ready_o, ptw_ready_o, lsu_data_o, ptw_data_o}, rsp_q.pop_front());
      end
    end
  end

  initial begin
    rst_i = 1'b1; kill_i = 1'b0; lsu_valid_i = 1'b1; ptw_valid_i = 1'b1;
    lsu_req_i = mk(40'h100); ptw_req_i = mk(40'h200);
    dc_lock_i = 1'b0; dc_ready_i = 1'b1; dc_data_i = 64'hFFFF;
    #2;
    chk("rst_lsu_lock", lsu_lock_o, 1);
    chk("rst_ptw_lock", ptw_lock_o, 1);
    chk("rst_dc_valid", dc_valid_o, 0);
    chk("rst_dc_req", dc_req_o, 0);
    chk("rst_owner", owner_o, 0);
    chk("rst_rsp", {lsu_ready_o, ptw_ready_o, lsu_data_o, ptw_data_o}, 0);
    repeat (2) cyc();
    lsu_valid_i = 1'b0; ptw_valid_i = 1'b0; dc_ready_i = 1'b0; rst_i = 1'b0;
    cyc();
    // both valid, starve count zero: PTW wins
    lsu_valid_i = 1'b1; ptw_valid_i = 1'b1;
    iss_q.push_back({1'b1, 40'h200});
    #2;
    chk("both_ptw_lock", ptw_lock_o, 0);
    chk("both_lsu_lock", lsu_lock_o, 1);
    cyc();
    ptw_valid_i = 1'b0;
    #2;
    chk("both_dc_valid", dc_valid_o, 1);
    chk("both_dc_req", dc_req_o, mk(40'h200));
    chk("both_owner", owner_o, 1);
    cyc();
    dc_ready_i = 1'b1; dc_data_i = 64'hA1;
    rsp_q.push_back(er(1'b1, 64'hA1));
    cyc();
    // LSU now alone: wins, then dcache locks for three cycles
    dc_ready_i = 1'b0;
    iss_q.push_back({1'b0, 40'h100});
    #2;
    chk("lsu_grant_lock", lsu_lock_o, 0);
    cyc();
    lsu_valid_i = 1'b0; dc_lock_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("locked_dc_valid", dc_valid_o, 1);
      chk("locked_dc_req", dc_req_o, mk(40'h100));
      cyc();
    end
    dc_lock_i = 1'b0;
    #2;
    chk("unlock_dc_valid", dc_valid_o, 1);
    chk("unlock_dc_req", dc_req_o, mk(40'h100));
    cyc();
    #2;
    chk("wait_dc_valid", dc_valid_o, 0);
    dc_ready_i = 1'b1; dc_data_i = 64'hB2;
    rsp_q.push_back(er(1'b0, 64'hB2));
    cyc();
    // starvation: PTW wins four times, fifth arbitration goes to LSU
    dc_ready_i = 1'b0;
    lsu_valid_i = 1'b1; lsu_req_i = mk(40'h300); ptw_valid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ptw_req_i = mk(40'h400 + 40'(k));
      iss_q.push_back({1'b1, 40'h400 + 40'(k)});
      #2;
      chk("starve_ptw_lock", ptw_lock_o, 0);
      cyc();
      cyc();
      dc_ready_i = 1'b1; dc_data_i = 64'hC0 + 64'(k);
      rsp_q.push_back(er(1'b1, 64'hC0 + 64'(k)));
      cyc();
      dc_ready_i = 1'b0;
    end
    ptw_req_i = mk(40'h500);
    iss_q.push_back({1'b0, 40'h300});
    #2;
    chk("starve_lsu_lock", lsu_lock_o, 0);
    chk("starve_ptw_lock_hi", ptw_lock_o, 1);
    cyc();
    lsu_valid_i = 1'b0; ptw_valid_i = 1'b0;
    cyc();
    dc_ready_i = 1'b1; dc_data_i = 64'hD0;
    rsp_q.push_back(er(1'b0, 64'hD0));
    cyc();
    // LSU killed in WAIT: drain, late response suppressed
    dc_ready_i = 1'b0;
    lsu_valid_i = 1'b1; lsu_req_i = mk(40'h600);
    iss_q.push_back({1'b0, 40'h600});
    cyc();
    lsu_valid_i = 1'b0;
    cyc();
    kill_i = 1'b1;
    cyc();
    kill_i = 1'b0;
    #2;
    chk("drain_dc_valid", dc_valid_o, 0);
    cyc();
    dc_ready_i = 1'b1; dc_data_i = 64'hDEAD;
    #2;
    chk("drain_rsp", {lsu_ready_o, lsu_data_o}, 0);
    cyc();
    // back in IDLE: PTW request ignores kill in ISSUE and WAIT
    dc_ready_i = 1'b0;
    ptw_valid_i = 1'b1; ptw_req_i = mk(40'h700);
    iss_q.push_back({1'b1, 40'h700});
    #2;
    chk("post_drain_ptw_lock", ptw_lock_o, 0);
    cyc();
    ptw_valid_i = 1'b0; kill_i = 1'b1;
    cyc();
    dc_ready_i = 1'b1; dc_data_i = 64'h1234;
    rsp_q.push_back(er(1'b1, 64'h1234));
    cyc();
    // LSU killed in ISSUE, kill blocks an IDLE grant, kill with same-cycle ready in WAIT
    kill_i = 1'b0; dc_ready_i = 1'b0;
    lsu_valid_i = 1'b1; lsu_req_i = mk(40'h800);
    #2;
    chk("kill_issue_grant", lsu_lock_o, 0);
    cyc();
    lsu_valid_i = 1'b0; kill_i = 1'b1;
    #2;
    chk("kill_issue_dc_valid", dc_valid_o, 0);
    cyc();
    lsu_valid_i = 1'b1; lsu_req_i = mk(40'h900);
    #2;
    chk("kill_idle_lock", lsu_lock_o, 1);
    cyc();
    kill_i = 1'b0;
    iss_q.push_back({1'b0, 40'h900});
    #2;
    chk("after_kill_lock", lsu_lock_o, 0);
    cyc();
    lsu_valid_i = 1'b0;
    cyc();
    kill_i = 1'b1; dc_ready_i = 1'b1; dc_data_i = 64'hEEEE;
    #2;
    chk("kill_ready_same", lsu_ready_o, 0);
    cyc();
    kill_i = 1'b0; dc_ready_i = 1'b0;
    ptw_valid_i = 1'b1; ptw_req_i = mk(40'hA00);
    iss_q.push_back({1'b1, 40'hA00});
    #2;
    chk("kill_same_idle", ptw_lock_o, 0);
    cyc();
    // reset in WAIT abandons the request; a late dcache response is ignored
    ptw_valid_i = 1'b0;
    cyc();
    #2;
    rst_i = 1'b1;
    #1;
    chk("midrst_owner", owner_o, 0);
    chk("midrst_dc", {dc_valid_o, dc_req_o}, 0);
    chk("midrst_locks", {lsu_lock_o, ptw_lock_o}, 2'b11);
    cyc();
    rst_i = 1'b0; dc_ready_i = 1'b1; dc_data_i = 64'hF00D;
    #2;
    chk("late_ready", {ptw_ready_o, ptw_data_o, lsu_ready_o}, 0);
    cyc();
    dc_ready_i = 1'b0;
    cyc();
    chk("iss_left", iss_q.size(), 0);
    chk("rsp_left", rsp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
